// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constant table, small sigma helpers,
// message schedule FSM state type and round count.
package sha256_pkg;

  localparam int unsigned SHA256_ROUNDS = 64;

  localparam logic [31:0] K [SHA256_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0_small(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1_small(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round constant lookup.
//   addr : round index 0..63
//   k    : K[addr], combinational
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  addr,
  output logic [31:0] k
);

  assign k = K[addr];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule producer. Accepts one 512-bit block and streams
// (W_t, K_t, t) for t = 0..63 over a valid/ready handshake, computing
// W_16..W_63 in a 16-word sliding window.
//   clk, rst_n              : clock, synchronous active-low reset
//   blk_valid_i/blk_ready_o : block input handshake, blk_i big-endian words
//   abort_i                 : drop current block, return to IDLE
//   w_valid_o/w_ready_i     : round input handshake
//   w_o, k_o, t_o, last_o   : W_t, K_t, t, (t == 63)
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_i,
  input  logic         abort_i,
  output logic         w_valid_o,
  input  logic         w_ready_i,
  output logic [31:0]  w_o,
  output logic [31:0]  k_o,
  output logic [5:0]   t_o,
  output logic         last_o
);

  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [5:0]  t_q;
  logic [31:0] k_q;
  logic [5:0]  rom_addr;
  logic [31:0] rom_k;
  logic [31:0] w_next;
  logic        accept;
  logic        xfer;

  assign accept = (state_q == IDLE) && blk_valid_i && !abort_i;
  assign xfer   = (state_q == RUN) && w_ready_i && !abort_i;

  // Window holds W_t..W_{t+15}; the new entry is W_{t+16}.
  assign w_next = sigma1_small(win_q[14]) + win_q[9] + sigma0_small(win_q[1]) + win_q[0];

  // In RUN the constant for the next round is prefetched; the 63->0 wrap
  // leaves K[0] behind after the last word, which is never presented.
  assign rom_addr = (state_q == IDLE) ? '0 : 6'(t_q + 6'd1);

  sha256_k_rom u_k_rom (
    .addr (rom_addr),
    .k    (rom_k)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (blk_valid_i) state_d = RUN;
        RUN:     if (w_ready_i && (t_q == 6'd63)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) win_q[i] <= '0;
      t_q <= '0;
      k_q <= '0;
    end else if (abort_i) begin
      t_q <= '0;
      k_q <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < 16; i++) win_q[i] <= blk_i[511 - 32*i -: 32];
      t_q <= '0;
      k_q <= rom_k;
    end else if (xfer) begin
      for (int unsigned i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
      win_q[15] <= w_next;
      t_q       <= 6'(t_q + 6'd1);
      k_q       <= rom_k;
    end
  end

  assign blk_ready_o = (state_q == IDLE);
  assign w_valid_o   = (state_q == RUN);
  assign w_o         = win_q[0];
  assign k_o         = k_q;
  assign t_o         = t_q;
  assign last_o      = (state_q == RUN) && (t_q == 6'd63);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

  typedef logic [31:0] wsched_t [64];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid_i = 1'b0;
  logic         blk_ready_o;
  logic [511:0] blk_i = '0;
  logic         abort_i = 1'b0;
  logic         w_valid_o;
  logic         w_ready_i = 1'b0;
  logic [31:0]  w_o;
  logic [31:0]  k_o;
  logic [5:0]   t_o;
  logic         last_o;

  int tests = 0;
  int fails = 0;

  sha256_msg_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .blk_valid_i (blk_valid_i),
    .blk_ready_o (blk_ready_o),
    .blk_i       (blk_i),
    .abort_i     (abort_i),
    .w_valid_o   (w_valid_o),
    .w_ready_i   (w_ready_i),
    .w_o         (w_o),
    .k_o         (k_o),
    .t_o         (t_o),
    .last_o      (last_o)
  );

  always #5 clk = ~clk;

  logic [31:0] kref [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Reference message expansion in the textbook W[t-2], W[t-7], W[t-15], W[t-16] form.
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic wsched_t expand(input logic [511:0] b);
    wsched_t w;
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
  endtask

  // Model state, updated on the falling edge from the inputs the DUT sees at the next rising edge.
  wsched_t     cur_w;
  int          exp_t = 0;
  bit          active = 1'b0;
  bit          after_reset = 1'b1;
  bit          chk_en = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_w, prev_k;
  logic [5:0]  prev_t;
  int          blocks_done = 0;
  int          hs_count = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (active) begin
        chk("w_valid_run", 32'(w_valid_o), 32'd1);
        chk("blk_ready_run", 32'(blk_ready_o), 32'd0);
        chk("w_word", w_o, cur_w[exp_t]);
        chk("k_word", k_o, kref[exp_t]);
        chk("t_index", 32'(t_o), 32'(exp_t));
        chk("last_flag", 32'(last_o), 32'(exp_t == 63));
        if (stall_prev) begin
          chk("stall_w_stable", w_o, prev_w);
          chk("stall_k_stable", k_o, prev_k);
          chk("stall_t_stable", 32'(t_o), 32'(prev_t));
        end
      end else begin
        chk("w_valid_idle", 32'(w_valid_o), 32'd0);
        chk("blk_ready_idle", 32'(blk_ready_o), 32'd1);
        chk("t_idle", 32'(t_o), 32'd0);
        chk("last_idle", 32'(last_o), 32'd0);
        if (after_reset) begin
          chk("w_reset", w_o, 32'd0);
          chk("k_reset", k_o, 32'd0);
        end
      end
    end
    stall_prev = 1'b0;
    if (!rst_n) begin
      active = 1'b0;
      after_reset = 1'b1;
    end else if (abort_i) begin
      if (active) after_reset = 1'b0;
      active = 1'b0;
    end else if (active) begin
      if (w_ready_i) begin
        hs_count++;
        if (exp_t == 63) begin
          if (chk_en) chk("transfers_per_block", 32'(hs_count), 32'd64);
          active = 1'b0;
          blocks_done++;
        end else begin
          exp_t++;
        end
      end else begin
        stall_prev = 1'b1;
        prev_w = w_o;
        prev_k = k_o;
        prev_t = t_o;
      end
    end else if (blk_valid_i) begin
      cur_w = expand(blk_i);
      exp_t = 0;
      hs_count = 0;
      active = 1'b1;
      after_reset = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic start_block(input logic [511:0] b);
    int n;
    blk_i = b;
    blk_valid_i = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!active && n < 20);
    if (!active) timeout_fail("block_accept");
    blk_valid_i = 1'b0;
  endtask

  // rmode 0: ready held high; 1: random ready; 2: random ready plus blk_valid/blk_i noise
  task automatic drain(input int rmode);
    int n = 0;
    while (active && n < 2000) begin
      w_ready_i = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (rmode == 2) begin
        blk_valid_i = 1'($urandom_range(0, 1));
        blk_i = rand_block();
      end
      tick();
      n++;
    end
    blk_valid_i = 1'b0;
    if (active) timeout_fail("block_drain");
  endtask

  task automatic wait_t(input int target);
    int n = 0;
    while (!(active && exp_t == target) && n < 500) begin
      tick();
      n++;
    end
    if (!(active && exp_t == target)) timeout_fail("wait_t");
  endtask

  initial begin
    logic [511:0] abc;
    wsched_t      ref_abc;
    int           base;
    int           n;

    abc = {32'h61626380, {14{32'h0}}, 32'h00000018};
    ref_abc = expand(abc);
    chk("model_W0", ref_abc[0], 32'h61626380);
    chk("model_W15", ref_abc[15], 32'h00000018);
    chk("model_W16", ref_abc[16], 32'h61626380);
    chk("model_W17", ref_abc[17], 32'h000f0000);

    rst_n = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    rst_n = 1'b1;
    tick();

    // "abc" block, no backpressure
    w_ready_i = 1'b1;
    start_block(abc);
    drain(0);
    tick();

    // random blocks under random backpressure
    for (int b = 0; b < 3; b++) begin
      start_block(rand_block());
      drain(1);
      tick();
    end

    // back-to-back blocks with blk_valid_i held high
    base = blocks_done;
    w_ready_i = 1'b1;
    blk_i = rand_block();
    blk_valid_i = 1'b1;
    n = 0;
    while (!active && n < 20) begin tick(); n++; end
    blk_i = rand_block();
    while (!(blocks_done == base + 1 && active) && n < 300) begin tick(); n++; end
    blk_valid_i = 1'b0;
    while (active && n < 400) begin tick(); n++; end
    if (blocks_done != base + 2) timeout_fail("back_to_back");
    tick();

    // abort at t = 20 while transferring
    start_block(rand_block());
    w_ready_i = 1'b1;
    wait_t(20);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    tick();
    start_block(rand_block());
    drain(0);
    tick();

    // abort at t = 20 while stalled
    start_block(rand_block());
    w_ready_i = 1'b1;
    wait_t(20);
    w_ready_i = 1'b0;
    tick();
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    tick();
    start_block(rand_block());
    drain(1);
    tick();

    // abort in IDLE overrides a block offer
    blk_i = rand_block();
    blk_valid_i = 1'b1;
    abort_i = 1'b1;
    tick();
    blk_valid_i = 1'b0;
    abort_i = 1'b0;
    tick();
    tick();

    // reset pulse at t = 40
    start_block(rand_block());
    w_ready_i = 1'b1;
    wait_t(40);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    start_block(rand_block());
    drain(1);
    tick();

    // blk_valid_i pulses and blk_i churn during RUN
    start_block(rand_block());
    drain(2);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Producer side of the SHA-256 round datapath.
- Accepts one 512-bit message block and streams the 64 round inputs (W_t, K_t), one pair per output handshake, to the round sequencer that drives the round cores.
- Holds a 16-word sliding window and computes W_16..W_63 on the fly.
- Backpressure from the consumer stalls the stream without loss.

Parameters:
- None. The block is fixed to SHA-256: 64 rounds, 32-bit words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- blk_valid_i  in  1  input block valid
- blk_ready_o  out  1  block accepted when blk_valid_i && blk_ready_o
- blk_i  in  512  message block; word 0 = blk_i[511:480], word 15 = blk_i[31:0] (big-endian word order)
- abort_i  in  1  flush current block, return to IDLE
- w_valid_o  out  1  w_o/k_o/t_o/last_o valid
- w_ready_i  in  1  consumer ready; transfer when w_valid_o && w_ready_i
- w_o  out  32  message schedule word W_t
- k_o  out  32  round constant K_t
- t_o  out  6  round index t
- last_o  out  1  high when t_o == 63

Behaviour:
- Clock and reset: clk; rst_n is synchronous, active-low.
- Reset values:
  - state = IDLE.
  - w_valid_o = 0, last_o = 0.
  - w_o, k_o, t_o and all 16 window words = 0.
- Ready: blk_ready_o = (state == IDLE), decoded combinationally from the state register. It is 1 in the first cycle after rst_n deasserts.
- FSM states:
  - IDLE: blk_ready_o = 1, w_valid_o = 0. On block accept:
    - load win[i] = word i of blk_i;
    - t = 0, k = K[0];
    - go to RUN.
  - RUN: blk_ready_o = 0, w_valid_o = 1. Outputs come directly from registers: w_o = win[0], k_o = k register, t_o = counter.
- Output handshake in RUN:
  - win[i] <= win[i+1] for i = 0..14.
  - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], mod 2^32. Invariant: win[i] = W_{t+i}.
  - t <= t+1, k <= K[t+1].
  - The win[15] update is computed unconditionally; values produced past W_63 are don't-care.
- Small sigmas:
  - sigma0(x) = rotr7 ^ rotr18 ^ shr3.
  - sigma1(x) = rotr17 ^ rotr19 ^ shr10.
- Stall: while w_valid_o && !w_ready_i, all outputs and internal state hold bit-stable.
- Last word: handshake with t == 63 -> next cycle state = IDLE, w_valid_o = 0, blk_ready_o = 1, t_o = 0, last_o = 0.
  - One bubble cycle between blocks; no same-cycle block accept.
- Latency and throughput:
  - Block accepted in cycle N -> W_0 presented in cycle N+1.
  - With w_ready_i held high: 64 words in 64 consecutive cycles; 65 cycles per block.
- abort_i (sampled every cycle):
  - Forces state = IDLE, w_valid_o = 0, t = 0 next cycle.
  - Takes priority over any same-cycle output handshake.
  - In IDLE it overrides a same-cycle block accept: the block is not taken. blk_ready_o stays combinational and may read 1 that cycle; the upstream producer treats abort as discarding the transfer.
- Reset mid-block: the block is discarded, reset values apply, and no partial output follows.
- Inputs ignored by state: w_ready_i is ignored in IDLE; blk_valid_i is ignored in RUN. blk_i need only be stable in the accept cycle.

Decomposition:
- Package sha256_pkg:
  - K table, 64 x 32-bit localparam array: K[0] = 0x428a2f98, K[63] = 0xc67178f2.
  - Functions rotr32, sigma0_small, sigma1_small.
  - State enum typedef (IDLE, RUN).
  - Constant SHA256_ROUNDS = 64.
- Sub-module sha256_k_rom: 6-bit address -> 32-bit constant, combinational, shareable with other round drivers.
- Window, counter and FSM stay in this module.

Test Plan:
- "abc" padded block (word0 = 0x61626380, words 1..14 = 0, word15 = 0x00000018), w_ready_i = 1 -> exactly these values, in order:
  - W0 = 0x61626380, K0 = 0x428a2f98, t = 0;
  - W15 = 0x00000018;
  - W16 = 0x61626380;
  - W17 = 0x000f0000;
  - last_o only on t = 63 with K = 0xc67178f2;
  - 64 transfers total; the golden model must match all 64 words.
- Random w_ready_i toggling (≈50%) on random blocks -> word sequence identical to the no-stall run; outputs stable during stalls; no dropped or duplicated t.
- Two blocks back-to-back with blk_valid_i held high -> second accept in the cycle after the t = 63 handshake; exactly one cycle with w_valid_o = 0.
- abort_i at t = 20 (while stalled and while transferring) -> w_valid_o = 0 next cycle, blk_ready_o = 1; the next block starts at t = 0 with its own W0.
- rst_n low for 1 cycle at t = 40 -> all outputs at reset values; blk_ready_o = 1 after release; no residual words emitted.
- blk_valid_i pulsed during RUN -> ignored; stream unaffected; blk_i changes during RUN have no effect.
